// File: rtl/spram_ctrl_if.sv
// Client-side bus of spram_ctrl: command handshake, write beat stream and read beat stream.
// The client is the master; spram_ctrl is the slave.
interface spram_ctrl_if #(
    parameter int unsigned WD = 8,
    parameter int unsigned AD = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AD-1:0] cmd_addr;
    logic [AD-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [WD-1:0] wr_data;
    logic          rd_valid;
    logic [WD-1:0] rd_data;
    logic          rd_last;
    logic          done;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done
    );
endinterface

// File: rtl/spram_ctrl.sv
// Burst master for a single-port SRAM with registered read data; wrapping auto-increment address.
// Optional SPRAM_CTRL_INIT_EN: after reset, zero-fill the whole SRAM before accepting commands.
module spram_ctrl #(
    parameter int unsigned WD = 8,
    parameter int unsigned AD = 4
) (
    input  logic          clk,
    input  logic          rst,
    spram_ctrl_if.slave   bus,
    output logic          mem_cs_n_o,
    output logic          mem_w_r_n_o,
    output logic [AD-1:0] mem_addr_o,
    output logic [WD-1:0] mem_din_o,
    input  logic [WD-1:0] mem_dout_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
`ifdef SPRAM_CTRL_INIT_EN
        , StInit
`endif
    } state_e;

    state_e        state_q;
    logic [AD-1:0] cur_q;
    logic [AD-1:0] rem_q;
    logic [1:0]    rd_vld_q;
    logic [1:0]    rd_lst_q;
    logic          done_q;
    logic          cs_n_q;
    logic          w_r_n_q;
    logic [AD-1:0] addr_q;
    logic [WD-1:0] din_q;
`ifdef SPRAM_CTRL_INIT_EN
    logic          init_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef SPRAM_CTRL_INIT_EN
            state_q <= StInit;
            rem_q   <= '1;
            init_q  <= 1'b1;
`else
            state_q <= StIdle;
            rem_q   <= '0;
`endif
            cur_q    <= '0;
            rd_vld_q <= '0;
            rd_lst_q <= '0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            w_r_n_q  <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            cs_n_q   <= 1'b1;
            done_q   <= 1'b0;
            rd_vld_q <= {rd_vld_q[0], 1'b0};
            rd_lst_q <= {rd_lst_q[0], 1'b0};
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        cur_q   <= bus.cmd_addr;
                        rem_q   <= bus.cmd_len;
                        state_q <= bus.cmd_wr ? StWrite : StRead;
                    end
                end
                StWrite: begin
                    if (bus.wr_valid) begin
                        cs_n_q  <= 1'b0;
                        w_r_n_q <= 1'b1;
                        addr_q  <= cur_q;
                        din_q   <= bus.wr_data;
                        cur_q   <= cur_q + 1'b1;
                        if (rem_q == '0) state_q <= StDrain;
                        else             rem_q   <= rem_q - 1'b1;
                    end
                end
                StRead: begin
                    cs_n_q   <= 1'b0;
                    w_r_n_q  <= 1'b0;
                    addr_q   <= cur_q;
                    cur_q    <= cur_q + 1'b1;
                    // Issue flags ride two stages to line up with the SRAM's registered output.
                    rd_vld_q <= {rd_vld_q[0], 1'b1};
                    rd_lst_q <= {rd_lst_q[0], rem_q == '0};
                    if (rem_q == '0) state_q <= StDrain;
                    else             rem_q   <= rem_q - 1'b1;
                end
                StDrain: begin
                    state_q <= StIdle;
`ifdef SPRAM_CTRL_INIT_EN
                    done_q  <= ~init_q;
                    init_q  <= 1'b0;
`else
                    done_q  <= 1'b1;
`endif
                end
`ifdef SPRAM_CTRL_INIT_EN
                StInit: begin
                    cs_n_q  <= 1'b0;
                    w_r_n_q <= 1'b1;
                    addr_q  <= cur_q;
                    din_q   <= '0;
                    cur_q   <= cur_q + 1'b1;
                    if (rem_q == '0) state_q <= StDrain;
                    else             rem_q   <= rem_q - 1'b1;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.wr_ready  = (state_q == StWrite);
    assign bus.rd_valid  = rd_vld_q[1];
    assign bus.rd_last   = rd_lst_q[1];
    assign bus.rd_data   = mem_dout_i;
    assign bus.done      = done_q;

    assign mem_cs_n_o  = cs_n_q;
    assign mem_w_r_n_o = w_r_n_q;
    assign mem_addr_o  = addr_q;
    assign mem_din_o   = din_q;

endmodule
